// File: rtl/eth_rx_parser_if.sv
// Word stream between the MAC receiver and the header parser: receive side in, payload side out.
// The master modport is the MAC/stimulus side; the slave modport is the parser.
interface eth_rx_parser_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_done;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;

  modport master (
    output in_data, in_valid, in_done,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_done,
    output out_data, out_valid, out_last
  );
endinterface

// File: rtl/eth_rx_parser.sv
// Ethernet header parser: walks dst/src/type words, filters on destination address,
// forwards the payload with one cycle of latency and keeps accepted/dropped frame counts.
module eth_rx_parser #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic        PROMISC   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  eth_rx_parser_if.slave     rx,
  output logic               hdr_valid,
  output logic [47:0]        src_mac,
  output logic [15:0]        ethertype,
  output logic               runt_err,
  output logic [15:0]        rx_count,
  output logic [15:0]        drop_count
);

  typedef enum logic [2:0] {IDLE, DST, SRC, TYPE, PAYLOAD, DROP} state_t;

  state_t      state_r, state_s;
  logic [1:0]  idx_r, idx_s;
  logic        loc_r, loc_s;
  logic        bc_r, bc_s;
  logic [47:0] stage_r, stage_s;
  logic [47:0] src_r, src_s;
  logic [15:0] type_r, type_s;
  logic [15:0] od_r, od_s;
  logic        ov_r, ov_s;
  logic        ol_r, ol_s;
  logic        hv_r, hv_s;
  logic        re_r, re_s;
  logic [15:0] rxc_r, rxc_s;
  logic [15:0] drc_r, drc_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state: the data word is consumed first, then in_done acts on the resulting state.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    loc_s   = loc_r;
    bc_s    = bc_r;
    stage_s = stage_r;
    src_s   = src_r;
    type_s  = type_r;
    od_s    = od_r;
    ov_s    = 1'b0;
    ol_s    = 1'b0;
    hv_s    = 1'b0;
    re_s    = 1'b0;
    rxc_s   = rxc_r;
    drc_s   = drc_r;

    if (rx.in_valid) begin
      case (state_r)
        IDLE: begin
          loc_s   = (rx.in_data == LOCAL_MAC[47:32]);
          bc_s    = (rx.in_data == 16'hFFFF);
          idx_s   = 2'd1;
          state_s = DST;
        end
        DST: begin
          if (idx_r == 2'd1) begin
            loc_s = loc_r & (rx.in_data == LOCAL_MAC[31:16]);
            bc_s  = bc_r & (rx.in_data == 16'hFFFF);
            idx_s = 2'd2;
          end else begin
            loc_s   = loc_r & (rx.in_data == LOCAL_MAC[15:0]);
            bc_s    = bc_r & (rx.in_data == 16'hFFFF);
            idx_s   = 2'd0;
            state_s = SRC;
          end
        end
        SRC: begin
          case (idx_r)
            2'd0: begin
              stage_s[47:32] = rx.in_data;
              idx_s          = 2'd1;
            end
            2'd1: begin
              stage_s[31:16] = rx.in_data;
              idx_s          = 2'd2;
            end
            default: begin
              stage_s[15:0] = rx.in_data;
              idx_s         = 2'd0;
              state_s       = TYPE;
            end
          endcase
        end
        TYPE: begin
          // Source address is staged so a dropped or runt frame leaves the last accepted header intact.
          if (loc_r | bc_r | PROMISC) begin
            type_s  = rx.in_data;
            src_s   = stage_r;
            hv_s    = 1'b1;
            state_s = PAYLOAD;
          end else begin
            state_s = DROP;
          end
        end
        PAYLOAD: begin
          od_s = rx.in_data;
          ov_s = 1'b1;
        end
        DROP:    state_s = DROP;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end

    if (rx.in_done) begin
      case (state_s)
        DST, SRC, TYPE: begin
          re_s    = 1'b1;
          state_s = IDLE;
        end
        PAYLOAD: begin
          ol_s    = 1'b1;
          rxc_s   = sat_inc(rxc_r);
          state_s = IDLE;
        end
        DROP: begin
          drc_s   = sat_inc(drc_r);
          state_s = IDLE;
        end
        default: state_s = IDLE;
      endcase
    end else begin
      ol_s = 1'b0;
    end
  end

  // State, flags, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      loc_r   <= 1'b0;
      bc_r    <= 1'b0;
      stage_r <= 48'd0;
      src_r   <= 48'd0;
      type_r  <= 16'd0;
      od_r    <= 16'd0;
      ov_r    <= 1'b0;
      ol_r    <= 1'b0;
      hv_r    <= 1'b0;
      re_r    <= 1'b0;
      rxc_r   <= 16'd0;
      drc_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      loc_r   <= loc_s;
      bc_r    <= bc_s;
      stage_r <= stage_s;
      src_r   <= src_s;
      type_r  <= type_s;
      od_r    <= od_s;
      ov_r    <= ov_s;
      ol_r    <= ol_s;
      hv_r    <= hv_s;
      re_r    <= re_s;
      rxc_r   <= rxc_s;
      drc_r   <= drc_s;
    end
  end

  assign rx.out_data  = od_r;
  assign rx.out_valid = ov_r;
  assign rx.out_last  = ol_r;
  assign hdr_valid    = hv_r;
  assign src_mac      = src_r;
  assign ethertype    = type_r;
  assign runt_err     = re_r;
  assign rx_count     = rxc_r;
  assign drop_count   = drc_r;

endmodule
